// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared mode constants and capacity helper for the configurable handshake pipe
package handshake_pkg;

    localparam int MODE_PASS  = 0;
    localparam int MODE_VALID = 1;
    localparam int MODE_READY = 2;
    localparam int MODE_BOTH  = 3;

    // Number of beats one slice of the given cut type can hold
    function automatic int slice_capacity(input int mode);
        case (mode)
            MODE_PASS:              return 0;
            MODE_VALID, MODE_READY: return 1;
            default:                return 2;
        endcase
    endfunction

endpackage

// File: rtl/handshake_slice.sv
// rtl/handshake_slice.sv - one valid/ready timing cut selected by MODE, with flush and held count
module handshake_slice
    import handshake_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MODE   = MODE_BOTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              master_valid,
    input  logic [DATA_W-1:0] master_data,
    output logic              master_ready,
    output logic              slave_valid,
    output logic [DATA_W-1:0] slave_data,
    input  logic              slave_ready,
    output logic [1:0]        count
);

    if (MODE == MODE_PASS) begin : g_pass
        // No state: the slice is a pair of wires
        assign slave_valid  = master_valid;
        assign slave_data   = master_data;
        assign master_ready = slave_ready;
        assign count        = 2'd0;

        logic unused;
        assign unused = ^{clk, rst_n, flush};

    end else if (MODE == MODE_VALID) begin : g_valid
        logic              out_valid;
        logic [DATA_W-1:0] out_data;

        // Ready is combinational from downstream so the slice streams at full rate
        assign master_ready = ~out_valid | slave_ready;
        assign slave_valid  = out_valid;
        assign slave_data   = out_data;
        assign count        = {1'b0, out_valid};

        // Forward register: load on upstream transfer, empty on downstream transfer without refill
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end else if (flush) begin
                out_valid <= 1'b0;
            end else if (master_valid && master_ready) begin
                out_valid <= 1'b1;
                out_data  <= master_data;
            end else if (slave_ready) begin
                out_valid <= 1'b0;
            end
        end

    end else if (MODE == MODE_READY) begin : g_ready
        logic              skid_valid;
        logic [DATA_W-1:0] skid_data;

        // Ready comes straight from a flop; valid/data bypass the skid when it is empty
        assign master_ready = ~skid_valid;
        assign slave_valid  = master_valid | skid_valid;
        assign slave_data   = skid_valid ? skid_data : master_data;
        assign count        = {1'b0, skid_valid};

        // Skid register: catch a beat the downstream refused, release it once taken
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else if (flush) begin
                skid_valid <= 1'b0;
            end else if (skid_valid) begin
                if (slave_ready) begin
                    skid_valid <= 1'b0;
                end
            end else if (master_valid && !slave_ready) begin
                skid_valid <= 1'b1;
                skid_data  <= master_data;
            end
        end

    end else begin : g_both
        logic              main_valid;
        logic [DATA_W-1:0] main_data;
        logic              skid_valid;
        logic [DATA_W-1:0] skid_data;
        logic              take_in;
        logic              take_out;

        // Both directions leave from flops; the skid absorbs the beat in flight when ready drops
        assign master_ready = ~skid_valid;
        assign slave_valid  = main_valid;
        assign slave_data   = main_data;
        assign count        = {1'b0, main_valid} + {1'b0, skid_valid};
        assign take_in      = master_valid & ~skid_valid;
        assign take_out     = main_valid & slave_ready;

        // Two-entry buffer: main feeds downstream, skid refills main when main is consumed
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_valid <= 1'b0;
                main_data  <= '0;
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (take_out) begin
                if (skid_valid) begin
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end else if (take_in) begin
                    main_data  <= master_data;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (take_in) begin
                if (!main_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= master_data;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= master_data;
                end
            end
        end
    end

endmodule

// File: rtl/handshake_pipe_cfg.sv
// rtl/handshake_pipe_cfg.sv - chain of STAGES handshake slices with flush gating and occupancy count
module handshake_pipe_cfg
    import handshake_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int STAGES = 1,
    parameter  int MODE   = MODE_BOTH,
    localparam int CNT_W  = $clog2(2*STAGES+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              master_valid,
    input  logic [DATA_W-1:0] master_data,
    output logic              master_ready,
    output logic              slave_valid,
    output logic [DATA_W-1:0] slave_data,
    input  logic              slave_ready,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int CAPACITY = STAGES * slice_capacity(MODE);

    // Each stage keeps its own link signals so the backward ready chain is not one vector
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic              mv;
        logic [DATA_W-1:0] md;
        logic              mr;
        logic              sv;
        logic [DATA_W-1:0] sd;
        logic              sr;
        logic [1:0]        cnt;
        logic [CNT_W-1:0]  acc;

        // Outer ports are gated by flush so nothing moves while the pipe is being emptied
        if (k == 0) begin : g_head
            assign mv  = master_valid & ~flush;
            assign md  = master_data;
            assign acc = CNT_W'(cnt);
        end else begin : g_link
            assign mv  = g_slice[k-1].sv;
            assign md  = g_slice[k-1].sd;
            assign acc = g_slice[k-1].acc + CNT_W'(cnt);
        end

        if (k == STAGES-1) begin : g_tail
            assign sr = slave_ready & ~flush;
        end else begin : g_mid
            assign sr = g_slice[k+1].mr;
        end

        handshake_slice #(
            .DATA_W (DATA_W),
            .MODE   (MODE)
        ) u_slice (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush        (flush),
            .master_valid (mv),
            .master_data  (md),
            .master_ready (mr),
            .slave_valid  (sv),
            .slave_data   (sd),
            .slave_ready  (sr),
            .count        (cnt)
        );
    end

    assign master_ready = g_slice[0].mr & ~flush;
    assign slave_valid  = g_slice[STAGES-1].sv & ~flush;
    assign slave_data   = g_slice[STAGES-1].sd;
    assign occupancy    = g_slice[STAGES-1].acc;

    // The held count can never exceed what the chain is able to store
    a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
        occupancy <= CNT_W'(CAPACITY));

endmodule

// File: tb/tb_handshake_pipe_cfg.sv
// tb/tb_handshake_pipe_cfg.sv - directed vectors and scoreboard soak for handshake_pipe_cfg
module tb_handshake_pipe_cfg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // A: MODE 3, STAGES 2
    logic a_fl = 0, a_mv = 0, a_sr = 1, a_mr, a_sv;
    logic [15:0] a_md = 0, a_sd;
    logic [2:0] a_occ;
    handshake_pipe_cfg #(.DATA_W(16), .STAGES(2), .MODE(3)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_fl), .master_valid(a_mv), .master_data(a_md),
        .master_ready(a_mr), .slave_valid(a_sv), .slave_data(a_sd), .slave_ready(a_sr),
        .occupancy(a_occ));

    // B: MODE 2, STAGES 1
    logic b_fl = 0, b_mv = 0, b_sr = 1, b_mr, b_sv;
    logic [15:0] b_md = 0, b_sd;
    logic [1:0] b_occ;
    handshake_pipe_cfg #(.DATA_W(16), .STAGES(1), .MODE(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_fl), .master_valid(b_mv), .master_data(b_md),
        .master_ready(b_mr), .slave_valid(b_sv), .slave_data(b_sd), .slave_ready(b_sr),
        .occupancy(b_occ));

    // C: MODE 3, STAGES 3
    logic c_fl = 0, c_mv = 0, c_sr = 1, c_mr, c_sv;
    logic [15:0] c_md = 0, c_sd;
    logic [2:0] c_occ;
    handshake_pipe_cfg #(.DATA_W(16), .STAGES(3), .MODE(3)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_fl), .master_valid(c_mv), .master_data(c_md),
        .master_ready(c_mr), .slave_valid(c_sv), .slave_data(c_sd), .slave_ready(c_sr),
        .occupancy(c_occ));

    // D: MODE 1, STAGES 4
    logic d_fl = 0, d_mv = 0, d_sr = 1, d_mr, d_sv;
    logic [15:0] d_md = 0, d_sd;
    logic [3:0] d_occ;
    handshake_pipe_cfg #(.DATA_W(16), .STAGES(4), .MODE(1)) u_d (
        .clk(clk), .rst_n(rst_n), .flush(d_fl), .master_valid(d_mv), .master_data(d_md),
        .master_ready(d_mr), .slave_valid(d_sv), .slave_data(d_sd), .slave_ready(d_sr),
        .occupancy(d_occ));

    // Random soak: every mode at STAGES 1 (g 0..3) and STAGES 3 (g 4..7)
    for (genvar g = 0; g < 8; g++) begin : gs
        localparam int SM  = g % 4;
        localparam int SS  = (g < 4) ? 1 : 3;
        localparam int SCW = $clog2(2*SS+1);
        logic s_fl = 0, s_mv = 0, s_sr = 1, s_mr, s_sv;
        logic [15:0] s_md = 0, s_sd;
        logic [SCW-1:0] s_occ;
        logic done = 0;
        logic [15:0] q[$];

        handshake_pipe_cfg #(.DATA_W(16), .STAGES(SS), .MODE(SM)) u_s (
            .clk(clk), .rst_n(rst_n), .flush(s_fl), .master_valid(s_mv), .master_data(s_md),
            .master_ready(s_mr), .slave_valid(s_sv), .slave_data(s_sd), .slave_ready(s_sr),
            .occupancy(s_occ));

        initial begin
            int acc, del, cyc;
            logic took, pv, pr;
            logic [15:0] pd, exp_d;
            acc = 0; del = 0; cyc = 0; took = 0; pv = 0; pr = 0; pd = 0;
            @(posedge rst_n);
            @(negedge clk);
            check("soak_rst_sv", 32'(s_sv), 32'd0);
            check("soak_rst_occ", 32'(s_occ), 32'd0);
            check("soak_rst_mr", 32'(s_mr), 32'd1);
            while (del < 1000 && cyc < 20000) begin
                @(posedge clk); #1;
                if (!(s_mv && !took)) begin
                    s_mv = (acc < 1000) && ($urandom_range(0, 3) != 0);
                    s_md = 16'($urandom);
                end
                s_sr = ($urandom_range(0, 9) < 6);
                @(negedge clk);
                if (pv && !pr) begin
                    check("soak_stall_valid", 32'(s_sv), 32'd1);
                    check("soak_stall_data", 32'(s_sd), 32'(pd));
                end
                check("soak_occ", 32'(s_occ), 32'(acc - del));
                took = s_mv && s_mr;
                if (took) begin
                    q.push_back(s_md);
                    acc++;
                end
                if (s_sv && s_sr) begin
                    exp_d = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                    check("soak_data", 32'(s_sd), 32'(exp_d));
                    del++;
                end
                pv = s_sv; pr = s_sr; pd = s_sd; cyc++;
            end
            s_mv = 0;
            check("soak_count", 32'(del), 32'd1000);
            done = 1;
        end
    end

    typedef struct {
        logic        fl;
        logic        mv;
        logic [15:0] md;
        logic        sr;
        logic        e_mr;
        logic        e_sv;
        logic [15:0] e_sd;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int acc, first, w;
        logic got;

        tbl[0]  = '{0, 1, 16'hA5, 0, 1, 1, 16'hA5, 0};
        tbl[1]  = '{0, 0, 16'h00, 0, 0, 1, 16'hA5, 1};
        tbl[2]  = '{0, 0, 16'h00, 1, 0, 1, 16'hA5, 1};
        tbl[3]  = '{0, 0, 16'h00, 1, 1, 0, 16'h00, 0};
        tbl[4]  = '{0, 1, 16'h3C, 1, 1, 1, 16'h3C, 0};
        tbl[5]  = '{0, 1, 16'h3D, 0, 1, 1, 16'h3D, 0};
        tbl[6]  = '{0, 1, 16'h3E, 0, 0, 1, 16'h3D, 1};
        tbl[7]  = '{0, 1, 16'h3E, 1, 0, 1, 16'h3D, 1};
        tbl[8]  = '{0, 1, 16'h3E, 1, 1, 1, 16'h3E, 0};
        tbl[9]  = '{1, 1, 16'h3F, 1, 0, 0, 16'h00, 0};
        tbl[10] = '{0, 0, 16'h00, 1, 1, 0, 16'h00, 0};

        // Reset held three cycles, then released
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("rst_a_sv", 32'(a_sv), 0); check("rst_a_occ", 32'(a_occ), 0); check("rst_a_mr", 32'(a_mr), 1);
        check("rst_b_sv", 32'(b_sv), 0); check("rst_b_occ", 32'(b_occ), 0); check("rst_b_mr", 32'(b_mr), 1);
        check("rst_c_sv", 32'(c_sv), 0); check("rst_c_occ", 32'(c_occ), 0); check("rst_c_mr", 32'(c_mr), 1);
        check("rst_d_sv", 32'(d_sv), 0); check("rst_d_occ", 32'(d_occ), 0); check("rst_d_mr", 32'(d_mr), 1);

        // Skid backpressure table on the MODE 2 single slice
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            b_fl = tbl[i].fl; b_mv = tbl[i].mv; b_md = tbl[i].md; b_sr = tbl[i].sr;
            @(negedge clk);
            check($sformatf("tbl%0d_mr", i), 32'(b_mr), 32'(tbl[i].e_mr));
            check($sformatf("tbl%0d_sv", i), 32'(b_sv), 32'(tbl[i].e_sv));
            if (tbl[i].e_sv) check($sformatf("tbl%0d_sd", i), 32'(b_sd), 32'(tbl[i].e_sd));
            check($sformatf("tbl%0d_occ", i), 32'(b_occ), 32'(tbl[i].e_occ));
        end

        // Streaming: ten back-to-back beats through two MODE 3 slices
        for (int c = 0; c < 14; c++) begin
            int exp_acc, exp_del;
            @(posedge clk); #1;
            a_mv = (c < 10); a_md = 16'(c + 1); a_sr = 1;
            @(negedge clk);
            exp_acc = (c < 10) ? c : 10;
            exp_del = (c > 2) ? ((c - 2 < 10) ? c - 2 : 10) : 0;
            if (c < 10) check($sformatf("stream%0d_mr", c), 32'(a_mr), 1);
            check($sformatf("stream%0d_sv", c), 32'(a_sv), 32'(c >= 2 && c < 12));
            if (c >= 2 && c < 12) check($sformatf("stream%0d_sd", c), 32'(a_sd), 32'(c - 1));
            check($sformatf("stream%0d_occ", c), 32'(a_occ), 32'(exp_acc - exp_del));
        end

        // Fill three MODE 3 slices with the output blocked
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            c_mv = 1; c_md = 16'(16'h10 + acc); c_sr = 0;
            @(negedge clk);
            if (c_mr) acc++;
        end
        check("fill_accepted", 32'(acc), 6);
        check("fill_mr", 32'(c_mr), 0);
        check("fill_occ", 32'(c_occ), 6);
        @(posedge clk); #1;
        c_mv = 0; c_sr = 1;
        first = 0;
        for (int c = 0; c < 20 && first < 6; c++) begin
            @(negedge clk);
            if (c_sv) begin
                check($sformatf("drain%0d", first), 32'(c_sd), 32'(16'h10 + first));
                first++;
            end
            @(posedge clk); #1;
        end
        check("drain_count", 32'(first), 6);
        check("drain_occ", 32'(c_occ), 0);

        // Flush four full MODE 1 slices while the master offers a beat
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            d_mv = 1; d_md = 16'(16'h20 + acc); d_sr = 0;
            @(negedge clk);
            if (d_mr) acc++;
        end
        check("flush_fill_acc", 32'(acc), 4);
        check("flush_fill_occ", 32'(d_occ), 4);
        @(posedge clk); #1;
        d_fl = 1; d_sr = 1;
        @(negedge clk);
        check("flush_mr", 32'(d_mr), 0);
        check("flush_sv", 32'(d_sv), 0);
        @(posedge clk); #1;
        d_fl = 0;
        @(negedge clk);
        check("flush_occ", 32'(d_occ), 0);
        got = 0; w = 0;
        while (!got && w < 20) begin
            if (d_sv) begin
                check("flush_next_beat", 32'(d_sd), 32'h24);
                got = 1;
            end
            if (d_mv && d_mr) begin
                @(posedge clk); #1;
                d_mv = 0;
            end else begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            w++;
        end
        check("flush_delivered", 32'(got), 1);

        // Wait for the soak processes, bounded
        w = 0;
        while (!(gs[0].done & gs[1].done & gs[2].done & gs[3].done &
                 gs[4].done & gs[5].done & gs[6].done & gs[7].done) && w < 30000) begin
            @(posedge clk);
            w++;
        end
        check("soak_all_done", 32'(gs[0].done & gs[1].done & gs[2].done & gs[3].done &
                                   gs[4].done & gs[5].done & gs[6].done & gs[7].done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_pipe_cfg.md
Name: handshake_pipe_cfg

Overview:
- Parametrised valid/ready pipeline that replaces the three fixed single-stage handshake pipes (valid-patting, ready-patting, both-patting) with one block.
- Timing-cut mode and number of chained stages are chosen per instance.
- Adds a synchronous flush and an occupancy count, so upstream stream stages can drain or discard in-flight data.
- Sits between any master/slave valid-ready pair in the datapath.

Parameters:
DATA_W  32  payload width in bits, 1..1024
STAGES  1  number of chained slices, 1..8
MODE  3  cut type per slice: 0 = pass-through, 1 = valid patting (forward register), 2 = ready patting (skid), 3 = both patting (registered valid and ready, 2-entry)
CNT_W  $clog2(2*STAGES+1)  occupancy width (derived, do not override)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of all held entries
master_valid  in  1  upstream valid
master_data  in  DATA_W  upstream payload
master_ready  out  1  upstream ready
slave_valid  out  1  downstream valid
slave_data  out  DATA_W  downstream payload
slave_ready  in  1  downstream ready
occupancy  out  CNT_W  entries currently held across all slices

Behaviour:
- Transfer rule: a beat moves on a port when valid & ready are high at a rising edge.
- Valid never drops and data never changes while valid & ~ready on the slave side. The block's outputs must obey this rule; the block assumes the master obeys it.
- Order is preserved. No beat is duplicated or lost except by flush.
- Slice k's slave side drives slice k+1's master side; k = 0 faces the master.
- Reset (rst_n low, asynchronous):
  - All slice valid/skid flags clear; data registers go to 0.
  - slave_valid = 0, occupancy = 0.
  - master_ready = 1 after release (MODE 3 ready register resets to 1).
- MODE 0:
  - Wires only: slave = master, master_ready = slave_ready.
  - Latency 0, occupancy contribution 0.
- MODE 1:
  - One output register.
  - master_ready = ~out_valid | slave_ready (combinational from slave_ready).
  - Loads on master transfer, clears on slave transfer with no new beat.
  - Latency 1, full throughput, capacity 1.
- MODE 2:
  - One skid register; master_ready = ~skid_valid (registered).
  - slave_valid = master_valid | skid_valid; slave_data = skid_valid ? skid_data : master_data.
  - Skid captures when master transfers and slave_ready = 0; skid releases on slave transfer.
  - Latency 0, full throughput, capacity 1.
- MODE 3:
  - Main plus skid register; both slave_valid and master_ready come from registers.
  - master_ready = ~skid_valid.
  - Beat goes to main if main is empty or being consumed, else to skid.
  - On consumption, skid moves to main.
  - Latency 1, full throughput, capacity 2.
- Total latency is the sum over slices. Capacity is STAGES × per-slice capacity; occupancy never exceeds it.
- occupancy is registered: it equals the count of set valid/skid flags after the edge.
  - Simultaneous in and out: count unchanged.
- flush:
  - While high, master_ready = 0 and slave_valid = 0 (combinational gating at the outer ports); no transfer occurs.
  - At the edge with flush high, all flags clear and occupancy = 0.
  - Data registers keep their values.
  - flush wins over a simultaneous transfer.
- A master beat presented with valid high during flush is not consumed; the master holds it until after flush.
- Reset mid-transfer: in-flight beats are lost. After rst_n rises, the first accepted beat is the first beat delivered.

Decomposition:
- Package handshake_pkg holds: mode constants MODE_PASS = 0, MODE_VALID = 1, MODE_READY = 2, MODE_BOTH = 3, and function slice_capacity(mode).
- Sub-module handshake_slice takes DATA_W and MODE and implements one cut, with a flush input and a 2-bit held-count output.
- The top level instantiates STAGES slices in a generate loop, sums their counts into occupancy, and applies the flush gating at the outer ports.

Test Plan:
- Reset, all modes, STAGES = 2: hold rst_n low 3 cycles, then release → slave_valid = 0, occupancy = 0, master_ready = 1 on the first cycle after release.
- Streaming, MODE 3, STAGES = 2, slave_ready tied 1, 10 back-to-back beats 0x1..0xA → 0x1 appears 2 cycles after acceptance, one beat per cycle, order preserved, occupancy steady at 2.
- Backpressure, MODE 2, STAGES = 1: send 0xA5 with slave_ready = 0 → slave_valid = 1 same cycle, skid holds 0xA5, master_ready = 0 next cycle, occupancy = 1. Raise slave_ready → 0xA5 delivered once, occupancy = 0.
- Fill, MODE 3, STAGES = 3, slave_ready = 0, master_valid held high → exactly 6 beats accepted, master_ready = 0, occupancy = 6. Release slave_ready → the 6 beats drain in order.
- Flush, MODE 1, STAGES = 4: fill to occupancy = 4, pulse flush 1 cycle with master_valid = 1 → no transfer either side that cycle, occupancy = 0 next cycle, next delivered beat is the one held by the master.
- Random soak, each MODE with STAGES ∈ {1, 3}: 1000 beats with random valid/ready → scoreboard matches, valid/data stable under stall, occupancy equals accepted minus delivered.
